vs_result_buffer: RTL and testbench

- Circular result buffer holding speculative/skipped-instruction results (ResultBufferEntryType: 32-bit result plus valid) for the value-skipping datapath.
- Sits directly downstream of the skip-table logic:
  - Skip logic allocates entries at issue.
  - Execute/load units write results.
  - Skip logic picks results up through an RBPickupType request (Enable, RBIdx).
- Entries retire in order from the head.

---
 rtl/vs_result_buffer.sv | 129 ++++++++++++
 tb/tb_vs_result_buffer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/vs_result_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vs_result_buffer                                              |
// | Purpose  : Circular result buffer for the value-skipping datapath:       |
// |            in-order alloc/retire, random-access write and pickup.        |
// | Option   : RB_PICKUP_BYPASS_EN enables write-to-pickup forwarding.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module vs_result_buffer #(
  parameter int RESULT_BUFFER_SIZE    = 8,
  parameter int DATA_W                = 32,
  parameter int RESULT_BUFFER_ID_SIZE = $clog2(RESULT_BUFFER_SIZE)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             alloc_req,
  output logic                             alloc_gnt,
  output logic [RESULT_BUFFER_ID_SIZE-1:0] alloc_idx,
  input  logic                             wr_en,
  input  logic [RESULT_BUFFER_ID_SIZE-1:0] wr_idx,
  input  logic [DATA_W-1:0]                wr_data,
  input  logic [RESULT_BUFFER_ID_SIZE:0]   pick,
  output logic                             pick_vld,
  output logic                             pick_hit,
  output logic [DATA_W-1:0]                pick_data,
  input  logic                             free_en,
  output logic [RESULT_BUFFER_ID_SIZE:0]   count,
  output logic                             full,
  output logic                             empty,
  output logic                             wr_err
);

  localparam logic [RESULT_BUFFER_ID_SIZE:0]   FULL_CNT = (RESULT_BUFFER_ID_SIZE+1)'(RESULT_BUFFER_SIZE);
  localparam logic [RESULT_BUFFER_ID_SIZE:0]   CNT_ONE  = (RESULT_BUFFER_ID_SIZE+1)'(1);
  localparam logic [RESULT_BUFFER_ID_SIZE-1:0] PTR_ONE  = RESULT_BUFFER_ID_SIZE'(1);

  logic [RESULT_BUFFER_SIZE-1:0]    alloc_q;
  logic [RESULT_BUFFER_SIZE-1:0]    valid_q;
  logic [DATA_W-1:0]                result_q [RESULT_BUFFER_SIZE];
  logic [RESULT_BUFFER_ID_SIZE-1:0] head;
  logic [RESULT_BUFFER_ID_SIZE-1:0] tail;

  logic                             pick_en;
  logic [RESULT_BUFFER_ID_SIZE-1:0] pick_idx;
  logic                             do_alloc;
  logic                             do_free;
  logic                             wr_ok;
  logic                             wr_bad;
  logic                             pick_hit_nxt;
  logic [DATA_W-1:0]                pick_data_nxt;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign alloc_gnt = alloc_req & ~full;
  assign alloc_idx = tail;

  assign pick_en   = pick[RESULT_BUFFER_ID_SIZE];
  assign pick_idx  = pick[RESULT_BUFFER_ID_SIZE-1:0];

  assign do_alloc  = alloc_gnt & ~flush;
  assign do_free   = free_en & ~empty & ~flush;
  // A write racing the retirement of the head entry loses to the free.
  assign wr_ok     = wr_en & alloc_q[wr_idx] & ~flush & ~(do_free && (wr_idx == head));
  assign wr_bad    = wr_en & ~alloc_q[wr_idx] & ~flush;

  always_comb begin
    pick_hit_nxt  = alloc_q[pick_idx] & valid_q[pick_idx];
    pick_data_nxt = result_q[pick_idx];
`ifdef RB_PICKUP_BYPASS_EN
    if (wr_ok && (wr_idx == pick_idx)) begin
      pick_hit_nxt  = 1'b1;
      pick_data_nxt = wr_data;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_q   <= '0;
      valid_q   <= '0;
      for (int i = 0; i < RESULT_BUFFER_SIZE; i++) result_q[i] <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      pick_vld  <= 1'b0;
      pick_hit  <= 1'b0;
      pick_data <= '0;
      wr_err    <= 1'b0;
    end else begin
      // Pickup responds even during flush, from pre-edge contents.
      pick_vld  <= pick_en;
      pick_hit  <= pick_en & pick_hit_nxt;
      pick_data <= (pick_en && pick_hit_nxt) ? pick_data_nxt : '0;

      if (flush) begin
        alloc_q <= '0;
        valid_q <= '0;
        head    <= '0;
        tail    <= '0;
        count   <= '0;
      end else begin
        if (wr_bad) wr_err <= 1'b1;
        if (wr_ok) begin
          result_q[wr_idx] <= wr_data;
          valid_q[wr_idx]  <= 1'b1;
        end
        if (do_alloc) begin
          alloc_q[tail]  <= 1'b1;
          valid_q[tail]  <= 1'b0;
          result_q[tail] <= '0;
          tail           <= tail + PTR_ONE;
        end
        if (do_free) begin
          alloc_q[head] <= 1'b0;
          valid_q[head] <= 1'b0;
          head          <= head + PTR_ONE;
        end
        case ({do_alloc, do_free})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vs_result_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_vs_result_buffer                                           |
// | Purpose  : Table-driven bench with pickup scoreboard for vs_result_buffer|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_vs_result_buffer;

`ifdef RB_PICKUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, alloc_req, alloc_gnt, wr_en, pick_vld, pick_hit, free_en, full, empty, wr_err;
  logic [2:0]  alloc_idx, wr_idx;
  logic [31:0] wr_data, pick_data;
  logic [3:0]  pick, count;

  always #5 clk = ~clk;

  vs_result_buffer dut (
    .clk(clk), .rst(rst), .flush(flush), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
    .alloc_idx(alloc_idx), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .pick(pick),
    .pick_vld(pick_vld), .pick_hit(pick_hit), .pick_data(pick_data), .free_en(free_en),
    .count(count), .full(full), .empty(empty), .wr_err(wr_err)
  );

  typedef struct {
    logic        ar, we;
    logic [2:0]  wi;
    logic [31:0] wd;
    logic        pe;
    logic [2:0]  pi;
    logic        fe, fl;
    logic        gnt;
    logic [2:0]  aidx;
    logic [3:0]  cnt;
    logic        err;
    logic        ph;
    logic [31:0] pd;
  } vec_t;

  typedef struct {
    logic        hit;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[28];
  vec_t hs[4];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(input logic ar, we, input logic [2:0] wi, input logic [31:0] wd,
                              input logic pe, input logic [2:0] pi, input logic fe, fl,
                              input logic gnt, input logic [2:0] aidx, input logic [3:0] cnt,
                              input logic err, ph, input logic [31:0] pd);
    vec_t v;
    v.ar = ar; v.we = we; v.wi = wi; v.wd = wd; v.pe = pe; v.pi = pi; v.fe = fe; v.fl = fl;
    v.gnt = gnt; v.aidx = aidx; v.cnt = cnt; v.err = err; v.ph = ph; v.pd = pd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: consumes the response to the pickup driven one step earlier.
  task automatic collect();
    exp_t e;
    if (pick_vld === 1'b1) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL pick_unexpected: got pick_vld=1 expected 0 (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("pick_hit", {31'b0, pick_hit}, {31'b0, e.hit});
        chk("pick_data", pick_data, e.data);
      end
    end else if (sb.size() != 0) begin
      e = sb.pop_front();
      tests++; fails++;
      $display("FAIL pick_vld_missing: got pick_vld=%b expected 1 (t=%0t)", pick_vld, $time);
    end else begin
      chk("pick_idle", {30'b0, pick_hit, (pick_data != 32'h0)}, 32'h0);
    end
  endtask

  task automatic apply_step(input vec_t v, input int n);
    logic [31:0] exp_full, exp_empty;
    @(negedge clk);
    collect();
    alloc_req = v.ar; wr_en = v.we; wr_idx = v.wi; wr_data = v.wd;
    pick = {v.pe, v.pi}; free_en = v.fe; flush = v.fl;
    #1;
    exp_full  = {31'b0, (v.cnt == 4'd8)};
    exp_empty = {31'b0, (v.cnt == 4'd0)};
    chk($sformatf("gnt[%0d]", n), {31'b0, alloc_gnt}, {31'b0, v.gnt});
    chk($sformatf("alloc_idx[%0d]", n), {29'b0, alloc_idx}, {29'b0, v.aidx});
    chk($sformatf("count[%0d]", n), {28'b0, count}, {28'b0, v.cnt});
    chk($sformatf("full[%0d]", n), {31'b0, full}, exp_full);
    chk($sformatf("empty[%0d]", n), {31'b0, empty}, exp_empty);
    chk($sformatf("wr_err[%0d]", n), {31'b0, wr_err}, {31'b0, v.err});
    if (v.pe) sb.push_back('{hit: v.ph, data: v.pd});
  endtask

  task automatic do_reset();
    @(negedge clk);
    collect();
    rst = 1'b1; flush = 0; alloc_req = 0; wr_en = 0; wr_idx = 0; wr_data = 0;
    pick = 0; free_en = 0;
    repeat (2) @(negedge clk);
    sb.delete();
    rst = 1'b0;
    #1;
    chk("rst_count", {28'b0, count}, 32'h0);
    chk("rst_empty", {31'b0, empty}, 32'h1);
    chk("rst_full", {31'b0, full}, 32'h0);
    chk("rst_wr_err", {31'b0, wr_err}, 32'h0);
    chk("rst_pick", {30'b0, pick_vld, pick_hit}, 32'h0);
    chk("rst_pick_data", pick_data, 32'h0);
    chk("rst_gnt_idx", {28'b0, alloc_gnt, alloc_idx}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; flush = 0; alloc_req = 0; wr_en = 0; wr_idx = 0; wr_data = 0; pick = 0; free_en = 0;

    //          ar we wi wd            pe pi fe fl  gnt aidx cnt err ph pd
    tbl[0]  = mk(1, 0, 0, 0,            0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0,            0, 0, 0, 0,  1, 1, 1, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0,            0, 0, 0, 0,  1, 2, 2, 0, 0, 0);
    tbl[3]  = mk(1, 1, 2, 32'hDEADBEEF, 0, 0, 0, 0,  1, 3, 3, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0,            1, 2, 0, 0,  0, 4, 4, 0, 1, 32'hDEADBEEF);
    tbl[5]  = mk(0, 0, 0, 0,            1, 3, 0, 0,  0, 4, 4, 0, 0, 0);
    tbl[6]  = mk(1, 0, 0, 0,            0, 0, 0, 0,  1, 4, 4, 0, 0, 0);
    tbl[7]  = mk(1, 0, 0, 0,            0, 0, 0, 0,  1, 5, 5, 0, 0, 0);
    tbl[8]  = mk(1, 0, 0, 0,            0, 0, 0, 0,  1, 6, 6, 0, 0, 0);
    tbl[9]  = mk(1, 0, 0, 0,            0, 0, 0, 0,  1, 7, 7, 0, 0, 0);
    tbl[10] = mk(1, 0, 0, 0,            0, 0, 0, 0,  0, 0, 8, 0, 0, 0);
    tbl[11] = mk(1, 0, 0, 0,            0, 0, 1, 0,  0, 0, 8, 0, 0, 0);
    tbl[12] = mk(1, 0, 0, 0,            0, 0, 0, 0,  1, 0, 7, 0, 0, 0);
    tbl[13] = mk(0, 1, 1, 32'hA1A1A1A1, 0, 0, 1, 0,  0, 1, 8, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 0,            1, 1, 0, 0,  0, 1, 7, 0, 0, 0);
    tbl[15] = mk(0, 1, 1, 32'h00000077, 0, 0, 0, 0,  0, 1, 7, 0, 0, 0);
    tbl[16] = mk(0, 0, 0, 0,            1, 1, 0, 0,  0, 1, 7, 1, 0, 0);
    tbl[17] = mk(0, 1, 3, 32'h33333333, 0, 0, 0, 0,  0, 1, 7, 1, 0, 0);
    tbl[18] = mk(1, 0, 0, 0,            1, 3, 0, 0,  1, 1, 7, 1, 1, 32'h33333333);
    tbl[19] = mk(0, 1, 3, 32'h44444444, 1, 3, 0, 0,  0, 2, 8, 1, 1,
                 BYP ? 32'h44444444 : 32'h33333333);
    tbl[20] = mk(0, 0, 0, 0,            1, 3, 0, 0,  0, 2, 8, 1, 1, 32'h44444444);
    tbl[21] = mk(1, 1, 4, 32'h99999999, 1, 2, 1, 1,  0, 2, 8, 1, 1, 32'hDEADBEEF);
    tbl[22] = mk(1, 0, 0, 0,            0, 0, 0, 0,  1, 0, 0, 1, 0, 0);
    tbl[23] = mk(0, 0, 0, 0,            1, 0, 0, 0,  0, 1, 1, 1, 0, 0);
    tbl[24] = mk(0, 0, 0, 0,            1, 2, 1, 0,  0, 1, 1, 1, 0, 0);
    tbl[25] = mk(1, 0, 0, 0,            0, 0, 1, 0,  1, 1, 0, 1, 0, 0);
    tbl[26] = mk(0, 0, 0, 0,            0, 0, 1, 0,  0, 2, 1, 1, 0, 0);
    tbl[27] = mk(0, 0, 0, 0,            0, 0, 0, 0,  0, 2, 0, 1, 0, 0);

    // Fresh-entry same-cycle write and pickup: result depends on forwarding.
    hs[0] = mk(1, 0, 0, 0,            0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    hs[1] = mk(0, 1, 0, 32'h12345678, 1, 0, 0, 0,  0, 1, 1, 0, BYP, BYP ? 32'h12345678 : 32'h0);
    hs[2] = mk(0, 0, 0, 0,            1, 0, 0, 0,  0, 1, 1, 0, 1, 32'h12345678);
    hs[3] = mk(0, 0, 0, 0,            0, 0, 0, 0,  0, 1, 1, 0, 0, 0);

    do_reset();
    for (int i = 0; i < 28; i++) apply_step(tbl[i], i);

    // Reset in the middle of activity drops contents and the sticky error.
    apply_step(mk(1, 0, 0, 0, 0, 0, 0, 0,  1, 2, 0, 1, 0, 0), 100);
    do_reset();
    apply_step(mk(0, 0, 0, 0, 1, 2, 0, 0,  0, 0, 0, 0, 0, 0), 101);

    do_reset();
    for (int i = 0; i < 4; i++) apply_step(hs[i], 200 + i);

    @(negedge clk);
    collect();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
